ttt_move_ctrl: RTL and testbench

Move controller and board register stage for the tic-tac-toe datapath. It accepts player moves through a valid/ready handshake and rejects illegal moves. It maintains the X and O occupancy boards and alternates turns. It drives the boards into the downstream win checker, then waits a fixed number of cycles for the checker's registered result before declaring the winner, a tie, or passing the turn.

---
 rtl/ttt_move_ctrl.sv | 135 +++++++++++++
 tb/tb_ttt_move_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: accepts moves, keeps the X/O boards, and
// resolves win/tie/next-turn after the downstream checker has settled.
//
// state     | meaning
// WAIT_MOVE | ready for a move from the current player
// SETTLE    | board updated, counting down until the checker result is valid
// OVER      | game finished, winner held until new_game or reset
module ttt_move_ctrl #(
    parameter int CHECK_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       win_x,
    input  logic       win_o,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn_o,
    output logic [3:0] move_cnt,
    output logic       move_err,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        WAIT_MOVE = 2'd0,
        SETTLE    = 2'd1,
        OVER      = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] settle_q;
    logic [8:0] board_x_q;
    logic [8:0] board_o_q;
    logic       turn_q;
    logic [3:0] move_cnt_q;
    logic       move_err_q;
    logic       game_over_q;
    logic [1:0] winner_q;
    logic       ready_q;

    logic [8:0] pos_oh;
    logic       illegal;

    // Positions above 8 shift the one-hot out of range, giving an empty mask.
    assign pos_oh  = 9'b1 << move_pos;
    assign illegal = (move_pos > 4'd8) || (|((board_x_q | board_o_q) & pos_oh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_MOVE;
            settle_q    <= 4'd0;
            board_x_q   <= 9'd0;
            board_o_q   <= 9'd0;
            turn_q      <= 1'b0;
            move_cnt_q  <= 4'd0;
            move_err_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            ready_q     <= 1'b1;
        end else if (new_game) begin
            state_q     <= WAIT_MOVE;
            settle_q    <= 4'd0;
            board_x_q   <= 9'd0;
            board_o_q   <= 9'd0;
            turn_q      <= 1'b0;
            move_cnt_q  <= 4'd0;
            move_err_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            ready_q     <= 1'b1;
        end else begin
            move_err_q <= 1'b0;
            case (state_q)
                WAIT_MOVE: begin
                    if (move_valid && ready_q) begin
                        if (illegal) begin
                            move_err_q <= 1'b1;
                        end else begin
                            if (turn_q) board_o_q <= board_o_q | pos_oh;
                            else        board_x_q <= board_x_q | pos_oh;
                            move_cnt_q <= move_cnt_q + 4'd1;
                            settle_q   <= 4'(CHECK_LAT);
                            ready_q    <= 1'b0;
                            state_q    <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_q == 4'd1) begin
                        settle_q <= 4'd0;
                        if (win_x) begin
                            winner_q    <= 2'b01;
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else if (win_o) begin
                            winner_q    <= 2'b10;
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else if (move_cnt_q == 4'd9) begin
                            winner_q    <= 2'b11;
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            ready_q <= 1'b1;
                            state_q <= WAIT_MOVE;
                        end
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                OVER: begin
                end
                default: begin
                    state_q <= WAIT_MOVE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign move_ready = ready_q;
    assign board_x    = board_x_q;
    assign board_o    = board_o_q;
    assign turn_o     = turn_q;
    assign move_cnt   = move_cnt_q;
    assign move_err   = move_err_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed bench for ttt_move_ctrl with a stub win checker that flags an
// X top-row win CHECK_LAT-1 cycles after it appears on the board.
module tb_ttt_move_ctrl;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       move_ready;
    logic       win_x, win_o;
    logic [8:0] board_x, board_o;
    logic       turn_o;
    logic [3:0] move_cnt;
    logic       move_err;
    logic       game_over;
    logic [1:0] winner;

    logic       stub_en = 1'b0;
    logic       fx = 1'b0;
    logic       fo = 1'b0;
    logic [3:0] sr = 4'd0;

    int errors = 0;
    int checks = 0;

    ttt_move_ctrl #(.CHECK_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
        .win_x(win_x), .win_o(win_o),
        .board_x(board_x), .board_o(board_o), .turn_o(turn_o),
        .move_cnt(move_cnt), .move_err(move_err),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sr <= {sr[2:0], stub_en && (board_x == 9'h007)};
    assign win_x = sr[L-2] | fx;
    assign win_o = fo;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] pos);
        int n;
        n = 0;
        while (!move_ready && n < 20) begin
            tick();
            n++;
        end
        check_val("ready_before_move", 16'(move_ready), 16'd1);
        move_valid = 1'b1;
        move_pos   = pos;
        tick();
        move_valid = 1'b0;
        check_val("ready_low_after_accept", 16'(move_ready), 16'd0);
    endtask

    task automatic play(input logic [3:0] pos);
        accept(pos);
        repeat (L) tick();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        // Reset held with a pending move request
        move_valid = 1'b1;
        move_pos   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_board_x", 16'(board_x), 16'h000);
        check_val("rst_ready", 16'(move_ready), 16'd1);
        rst_n = 1'b1;
        #1;
        move_valid = 1'b0;
        check_val("rst_board_o", 16'(board_o), 16'h000);
        check_val("rst_turn", 16'(turn_o), 16'd0);
        check_val("rst_winner", 16'(winner), 16'd0);
        check_val("rst_err", 16'(move_err), 16'd0);
        check_val("rst_cnt", 16'(move_cnt), 16'd0);
        tick();

        // X wins on the top row through the stub checker
        stub_en = 1'b1;
        play(4'd0);
        check_val("g1_turn_after_x", 16'(turn_o), 16'd1);
        check_val("g1_ready_after_settle", 16'(move_ready), 16'd1);
        play(4'd3);
        check_val("g1_turn_after_o", 16'(turn_o), 16'd0);
        play(4'd1);
        play(4'd4);
        check_val("g1_cnt4", 16'(move_cnt), 16'd4);
        accept(4'd2);
        check_val("g1_board_x", 16'(board_x), 16'h007);
        check_val("g1_board_o", 16'(board_o), 16'h018);
        check_val("g1_cnt5", 16'(move_cnt), 16'd5);
        repeat (L-1) tick();
        check_val("g1_over_early", 16'(game_over), 16'd0);
        tick();
        check_val("g1_over", 16'(game_over), 16'd1);
        check_val("g1_winner", 16'(winner), 16'b01);
        check_val("g1_ready_over", 16'(move_ready), 16'd0);

        // Requests during OVER are ignored
        move_valid = 1'b1;
        move_pos   = 4'd5;
        tick();
        check_val("over_no_err", 16'(move_err), 16'd0);
        tick();
        move_valid = 1'b0;
        check_val("over_board_o", 16'(board_o), 16'h018);
        check_val("over_cnt", 16'(move_cnt), 16'd5);

        // new_game out of OVER
        stub_en = 1'b0;
        do_new_game();
        check_val("ng_board_x", 16'(board_x), 16'h000);
        check_val("ng_over", 16'(game_over), 16'd0);
        check_val("ng_winner", 16'(winner), 16'd0);
        check_val("ng_ready", 16'(move_ready), 16'd1);
        check_val("ng_cnt", 16'(move_cnt), 16'd0);
        play(4'd4);
        check_val("ng_fresh_x", 16'(board_x), 16'h010);

        // Occupied cell then out-of-range cell, back-to-back
        move_valid = 1'b1;
        move_pos   = 4'd4;
        tick();
        check_val("err_occupied", 16'(move_err), 16'd1);
        move_pos = 4'd9;
        tick();
        check_val("err_range", 16'(move_err), 16'd1);
        move_valid = 1'b0;
        tick();
        check_val("err_clear", 16'(move_err), 16'd0);
        check_val("err_board_x", 16'(board_x), 16'h010);
        check_val("err_board_o", 16'(board_o), 16'h000);
        check_val("err_turn", 16'(turn_o), 16'd1);
        check_val("err_cnt", 16'(move_cnt), 16'd1);

        // O moves; a request held through SETTLE is ignored
        accept(4'd0);
        move_valid = 1'b1;
        move_pos   = 4'd8;
        repeat (L-1) begin
            tick();
            check_val("settle_no_err", 16'(move_err), 16'd0);
        end
        move_valid = 1'b0;
        tick();
        check_val("settle_board_x", 16'(board_x), 16'h010);
        check_val("settle_board_o", 16'(board_o), 16'h001);
        check_val("settle_cnt", 16'(move_cnt), 16'd2);
        check_val("settle_turn", 16'(turn_o), 16'd0);

        // Async reset in the middle of SETTLE
        accept(4'd8);
        check_val("mid_cnt", 16'(move_cnt), 16'd3);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_board_x", 16'(board_x), 16'h000);
        check_val("async_board_o", 16'(board_o), 16'h000);
        check_val("async_cnt", 16'(move_cnt), 16'd0);
        check_val("async_ready", 16'(move_ready), 16'd1);
        #2 rst_n = 1'b1;
        repeat (L+1) tick();
        check_val("async_no_decision_turn", 16'(turn_o), 16'd0);
        check_val("async_no_decision_over", 16'(game_over), 16'd0);
        play(4'd8);
        check_val("async_fresh_x", 16'(board_x), 16'h100);

        // Both flags high: X has priority
        do_new_game();
        fx = 1'b1;
        fo = 1'b1;
        play(4'd0);
        fx = 1'b0;
        fo = 1'b0;
        check_val("prio_winner_x", 16'(winner), 16'b01);
        check_val("prio_over", 16'(game_over), 16'd1);

        do_new_game();
        fo = 1'b1;
        play(4'd0);
        fo = 1'b0;
        check_val("o_winner", 16'(winner), 16'b10);

        // new_game wins over a simultaneous move
        do_new_game();
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd2;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        check_val("ng_move_board_x", 16'(board_x), 16'h000);
        check_val("ng_move_cnt", 16'(move_cnt), 16'd0);
        check_val("ng_move_ready", 16'(move_ready), 16'd1);

        // Full board without a winner
        play(4'd0); play(4'd1); play(4'd2); play(4'd4);
        play(4'd3); play(4'd5); play(4'd7); play(4'd6);
        check_val("tie_not_over_at_8", 16'(game_over), 16'd0);
        play(4'd8);
        check_val("tie_cnt", 16'(move_cnt), 16'd9);
        check_val("tie_winner", 16'(winner), 16'b11);
        check_val("tie_over", 16'(game_over), 16'd1);
        check_val("tie_board_x", 16'(board_x), 16'h18D);
        check_val("tie_full", 16'(board_x | board_o), 16'h1FF);
        check_val("tie_disjoint", 16'(board_x & board_o), 16'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
